// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg : shared branch-predictor types, widths and counter helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bp_pkg;

  localparam int PC_W = 32;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CNT_ST) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CNT_SNT) ? c : c - 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_sat_counter.sv
// ---------------------------------------------------------------------------
// bp_sat_counter : next value of a 2-bit prediction counter for one update
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bp_sat_counter
  import bp_pkg::*;
#(
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic [1:0] cnt_cur,
  input  logic       hit,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  // A miss only ever reaches the table when taken, so it always allocates.
  always_comb begin
    cnt_next = CNT_INIT;
    if (hit) begin
      cnt_next = taken ? sat_inc(cnt_cur) : sat_dec(cnt_cur);
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer : direct-mapped BTB with 2-bit counters, IF lookup and
// EX resolution/training. Optional BTB_PERF_CNT_EN adds branch/miss counters.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int         IDX_W    = 6,
  parameter int         TAG_W    = 8,
  parameter logic [1:0] CNT_INIT = 2'b10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pcf_i,
  output logic            pred_taken_o,
  output logic [PC_W-1:0] pred_npc_o,
  input  logic            ex_valid_i,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic            ex_taken_i,
  input  logic [PC_W-1:0] ex_target_i,
  input  logic            ex_pred_i,
  input  logic [PC_W-1:0] ex_pred_npc_i,
  output logic            mispredict_o,
  output logic [PC_W-1:0] redirect_pc_o,
`ifdef BTB_PERF_CNT_EN
  output logic [31:0]     br_cnt_o,
  output logic [31:0]     miss_cnt_o,
`endif
  input  logic            inv_all_i
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic             valid  [ENTRIES];
  logic [TAG_W-1:0] tag    [ENTRIES];
  logic [PC_W-1:0]  target [ENTRIES];
  logic [1:0]       cnt    [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic [PC_W-1:0]  actual_npc;
  logic [1:0]       cnt_next;
  logic             unused_pred;

  // PredE is carried for the pipeline; the NPC comparison alone decides mispredicts.
  assign unused_pred = ex_pred_i;

  assign f_idx = pcf_i[IDX_W+1:2];
  assign f_tag = pcf_i[IDX_W+TAG_W+1:IDX_W+2];
  assign f_hit = valid[f_idx] && (tag[f_idx] == f_tag);

  assign pred_taken_o = f_hit && cnt[f_idx][1];
  assign pred_npc_o   = pred_taken_o ? target[f_idx] : pcf_i + 32'd4;

  assign actual_npc    = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
  assign mispredict_o  = ex_valid_i && (actual_npc != ex_pred_npc_i);
  assign redirect_pc_o = actual_npc;

  assign e_idx = ex_pc_i[IDX_W+1:2];
  assign e_tag = ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign e_hit = valid[e_idx] && (tag[e_idx] == e_tag);

  bp_sat_counter #(
    .CNT_INIT (CNT_INIT)
  ) u_upd_cnt (
    .cnt_cur  (cnt[e_idx]),
    .hit      (e_hit),
    .taken    (ex_taken_i),
    .cnt_next (cnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        cnt[i]    <= CNT_WNT;
      end
    end else if (inv_all_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
      end
    end else if (ex_valid_i && (e_hit || ex_taken_i)) begin
      // Hit-not-taken rewrites the same tag, so the entry stays valid.
      valid[e_idx] <= 1'b1;
      tag[e_idx]   <= e_tag;
      cnt[e_idx]   <= cnt_next;
      if (ex_taken_i) begin
        target[e_idx] <= ex_target_i;
      end
    end
  end

`ifdef BTB_PERF_CNT_EN
  logic [31:0] br_cnt, miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (ex_valid_i)   br_cnt   <= br_cnt + 32'd1;
      if (mispredict_o) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign br_cnt_o   = br_cnt;
  assign miss_cnt_o = miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer : directed table-driven bench for branch_target_buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pcf_i = '0;
  logic        pred_taken_o;
  logic [31:0] pred_npc_o;
  logic        ex_valid_i = 1'b0;
  logic [31:0] ex_pc_i = '0;
  logic        ex_taken_i = 1'b0;
  logic [31:0] ex_target_i = '0;
  logic        ex_pred_i = 1'b0;
  logic [31:0] ex_pred_npc_i = '0;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic        inv_all_i = 1'b0;
`ifdef BTB_PERF_CNT_EN
  logic [31:0] br_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_target_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pcf_i         (pcf_i),
    .pred_taken_o  (pred_taken_o),
    .pred_npc_o    (pred_npc_o),
    .ex_valid_i    (ex_valid_i),
    .ex_pc_i       (ex_pc_i),
    .ex_taken_i    (ex_taken_i),
    .ex_target_i   (ex_target_i),
    .ex_pred_i     (ex_pred_i),
    .ex_pred_npc_i (ex_pred_npc_i),
    .mispredict_o  (mispredict_o),
    .redirect_pc_o (redirect_pc_o),
`ifdef BTB_PERF_CNT_EN
    .br_cnt_o      (br_cnt_o),
    .miss_cnt_o    (miss_cnt_o),
`endif
    .inv_all_i     (inv_all_i)
  );

  typedef struct {
    logic [31:0] pcf;
    logic        exv;
    logic [31:0] expc;
    logic        ext;
    logic [31:0] extgt;
    logic [31:0] expnpc;
    logic        inv;
    logic        e_tk;
    logic [31:0] e_npc;
    logic        e_mp;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] pcf, input logic exv, input logic [31:0] expc,
                     input logic ext, input logic [31:0] extgt, input logic [31:0] expnpc,
                     input logic inv, input logic e_tk, input logic [31:0] e_npc,
                     input logic e_mp, input logic [31:0] e_rd);
    vec_t v;
    v.pcf = pcf; v.exv = exv; v.expc = expc; v.ext = ext; v.extgt = extgt;
    v.expnpc = expnpc; v.inv = inv; v.e_tk = e_tk; v.e_npc = e_npc;
    v.e_mp = e_mp; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic t,
                          input logic [31:0] tgt, input logic [31:0] pnpc);
    ex_valid_i = v; ex_pc_i = pc; ex_taken_i = t; ex_target_i = tgt;
    ex_pred_npc_i = pnpc; ex_pred_i = (pnpc != pc + 32'd4);
  endtask

  initial begin
    int exp_br;
    int exp_miss;
    exp_br = 0;
    exp_miss = 0;

    //   pcf           exv ex_pc        t  target       pred_npc     inv  tk npc          mp redirect
    add(32'h100,       0, 32'h0,       0, 32'h0,       32'h0,       0,   0, 32'h104,     0, 32'h4);
    add(32'h100,       1, 32'h100,     1, 32'h40,      32'h104,     0,   0, 32'h104,     1, 32'h40);
    add(32'h100,       0, 32'h0,       0, 32'h0,       32'h0,       0,   1, 32'h40,      0, 32'h4);
    add(32'h100,       1, 32'h100,     0, 32'h0,       32'h40,      0,   1, 32'h40,      1, 32'h104);
    add(32'h100,       1, 32'h100,     0, 32'h0,       32'h104,     0,   0, 32'h104,     0, 32'h104);
    add(32'h100,       1, 32'h100,     1, 32'h40,      32'h104,     0,   0, 32'h104,     1, 32'h40);
    add(32'h100,       0, 32'h0,       0, 32'h0,       32'h0,       0,   0, 32'h104,     0, 32'h4);
    add(32'h100,       1, 32'h100,     1, 32'h80,      32'h40,      0,   0, 32'h104,     1, 32'h80);
    add(32'h100,       1, 32'h300,     0, 32'h0,       32'h304,     0,   1, 32'h80,      0, 32'h304);
    add(32'h100,       0, 32'h500,     1, 32'h999,     32'h0,       0,   1, 32'h80,      0, 32'h999);
    add(32'h100,       1, 32'h200,     1, 32'h600,     32'h204,     0,   1, 32'h80,      1, 32'h600);
    add(32'h100,       0, 32'h0,       0, 32'h0,       32'h0,       0,   0, 32'h104,     0, 32'h4);
    add(32'h200,       1, 32'h104,     1, 32'h700,     32'h108,     1,   1, 32'h600,     1, 32'h700);
    add(32'h104,       0, 32'h0,       0, 32'h0,       32'h0,       0,   0, 32'h108,     0, 32'h4);
    add(32'h200,       0, 32'h0,       0, 32'h0,       32'h0,       0,   0, 32'h204,     0, 32'h4);
    add(32'hFFFFFFFC,  1, 32'hFFFFFFFC,0, 32'h0,       32'h0,       0,   0, 32'h0,       0, 32'h0);
    add(32'h104,       1, 32'h104,     1, 32'h700,     32'h108,     0,   0, 32'h108,     1, 32'h700);
    add(32'h104,       1, 32'h104,     1, 32'h700,     32'h700,     0,   1, 32'h700,     0, 32'h700);
    add(32'h104,       1, 32'h104,     1, 32'h700,     32'h700,     0,   1, 32'h700,     0, 32'h700);
    add(32'h104,       1, 32'h104,     0, 32'h0,       32'h700,     0,   1, 32'h700,     1, 32'h108);
    add(32'h104,       0, 32'h0,       0, 32'h0,       32'h0,       0,   1, 32'h700,     0, 32'h4);
    add(32'h104,       1, 32'h104,     0, 32'h0,       32'h700,     0,   1, 32'h700,     1, 32'h108);
    add(32'h104,       1, 32'h104,     0, 32'h0,       32'h108,     0,   0, 32'h108,     0, 32'h108);
    add(32'h104,       1, 32'h104,     0, 32'h0,       32'h108,     0,   0, 32'h108,     0, 32'h108);
    add(32'h104,       1, 32'h104,     0, 32'h0,       32'h108,     0,   0, 32'h108,     0, 32'h108);
    add(32'h104,       0, 32'h0,       0, 32'h0,       32'h0,       0,   0, 32'h108,     0, 32'h4);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      pcf_i = vecs[i].pcf;
      inv_all_i = vecs[i].inv;
      drive_ex(vecs[i].exv, vecs[i].expc, vecs[i].ext, vecs[i].extgt, vecs[i].expnpc);
      #2;
      check($sformatf("vec%0d pred_taken", i), {31'b0, pred_taken_o}, {31'b0, vecs[i].e_tk});
      check($sformatf("vec%0d pred_npc", i), pred_npc_o, vecs[i].e_npc);
      check($sformatf("vec%0d mispredict", i), {31'b0, mispredict_o}, {31'b0, vecs[i].e_mp});
      check($sformatf("vec%0d redirect", i), redirect_pc_o, vecs[i].e_rd);
      if (vecs[i].exv) exp_br++;
      if (vecs[i].e_mp) exp_miss++;
    end

    @(negedge clk);
    inv_all_i = 1'b0;
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
`ifdef BTB_PERF_CNT_EN
    #2;
    check("perf br_cnt", br_cnt_o, exp_br);
    check("perf miss_cnt", miss_cnt_o, exp_miss);
`endif

    // Reset sequence: a live entry is wiped and an in-flight allocation is dropped.
    @(negedge clk);
    pcf_i = 32'h180;
    drive_ex(1'b1, 32'h180, 1'b1, 32'h900, 32'h184);
    @(negedge clk);
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    #2;
    check("rst_seq trained taken", {31'b0, pred_taken_o}, 32'd1);
    check("rst_seq trained npc", pred_npc_o, 32'h900);
    @(negedge clk);
    drive_ex(1'b1, 32'h280, 1'b1, 32'hA00, 32'h284);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_seq async taken", {31'b0, pred_taken_o}, 32'd0);
    check("rst_seq async npc", pred_npc_o, 32'h184);
    check("rst_seq comb mispredict", {31'b0, mispredict_o}, 32'd1);
    @(negedge clk);
    drive_ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    pcf_i = 32'h280;
    #2;
    check("rst_seq dropped alloc taken", {31'b0, pred_taken_o}, 32'd0);
    check("rst_seq dropped alloc npc", pred_npc_o, 32'h284);
`ifdef BTB_PERF_CNT_EN
    check("rst_seq perf br_cnt", br_cnt_o, 32'd0);
    check("rst_seq perf miss_cnt", miss_cnt_o, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
